// File: rtl/fabric_result_checker.sv
// Compares fabric data/config outputs against delay-aligned golden values, counts
// mismatches with saturation, captures the first data failure and issues a verdict.
module fabric_result_checker #(
   parameter int DATA_OUT_WIRE_WIDTH = 36,
   parameter int LATENCY             = 1,
   parameter int CNT_WIDTH           = 16
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_check_en,
   input  logic [DATA_OUT_WIRE_WIDTH-1:0] i_data_out,
   input  logic [DATA_OUT_WIRE_WIDTH-1:0] i_expected_dataout,
   input  logic [DATA_OUT_WIRE_WIDTH-1:0] i_dout_mask,
   input  logic                           i_cfg_valid,
   input  logic                           i_config_out,
   input  logic                           i_expected_config_out,
   input  logic                           i_sim_done,
   output logic [CNT_WIDTH-1:0]           o_data_err_count,
   output logic [CNT_WIDTH-1:0]           o_cfg_err_count,
   output logic [CNT_WIDTH-1:0]           o_compare_count,
   output logic [CNT_WIDTH-1:0]           o_first_err_index,
   output logic [DATA_OUT_WIRE_WIDTH-1:0] o_first_err_vec,
   output logic                           o_err_pulse,
   output logic                           o_done,
   output logic                           o_pass
);
   localparam int                DOW     = DATA_OUT_WIRE_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [3:0]        LAT4    = 4'(LATENCY);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [3:0]       r_drain_cnt, w_drain_nxt;
   logic             w_cmp_v;
   logic [DOW-1:0]   w_exp_d, w_mask_d;

   // Delay line aligns golden data and its valid/mask with the fabric pipeline.
   generate
      if (LATENCY == 0) begin : g_bypass
         assign w_cmp_v  = i_check_en;
         assign w_exp_d  = i_expected_dataout;
         assign w_mask_d = i_dout_mask;
      end else begin : g_dly
         logic           r_v    [LATENCY];
         logic [DOW-1:0] r_exp  [LATENCY];
         logic [DOW-1:0] r_mask [LATENCY];
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               for (int i = 0; i < LATENCY; i++) begin
                  r_v[i]    <= 1'b0;
                  r_exp[i]  <= '0;
                  r_mask[i] <= '0;
               end
            end else begin
               r_v[0]    <= i_check_en;
               r_exp[0]  <= i_expected_dataout;
               r_mask[0] <= i_dout_mask;
               for (int i = 1; i < LATENCY; i++) begin
                  r_v[i]    <= r_v[i-1];
                  r_exp[i]  <= r_exp[i-1];
                  r_mask[i] <= r_mask[i-1];
               end
            end
         end
         assign w_cmp_v  = r_v[LATENCY-1];
         assign w_exp_d  = r_exp[LATENCY-1];
         assign w_mask_d = r_mask[LATENCY-1];
      end
   endgenerate

   always_comb begin
      w_state_nxt = r_state;
      w_drain_nxt = r_drain_cnt;
      case (r_state)
         S_IDLE: begin
            if (i_sim_done) begin
               w_state_nxt = S_DRAIN;
               w_drain_nxt = LAT4;
            end else if (i_check_en || i_cfg_valid) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (i_sim_done) begin
               w_state_nxt = S_DRAIN;
               w_drain_nxt = LAT4;
            end
         end
         S_DRAIN: begin
            if (r_drain_cnt == 4'd0) w_state_nxt = S_DONE;
            else                     w_drain_nxt = r_drain_cnt - 4'd1;
         end
         S_DONE:  w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   logic           w_cmp_act, w_data_err, w_cfg_err;
   logic [DOW-1:0] w_diff;

   assign w_cmp_act  = w_cmp_v && ((r_state == S_RUN) || (r_state == S_DRAIN));
   assign w_diff     = (i_data_out ^ w_exp_d) & w_mask_d;
   assign w_data_err = w_cmp_act && (|w_diff);
   assign w_cfg_err  = i_cfg_valid && (r_state != S_DONE) &&
                       (i_config_out != i_expected_config_out);

   logic [CNT_WIDTH-1:0] r_data_err_count, r_cfg_err_count, r_compare_count, r_first_err_index;
   logic [DOW-1:0]       r_first_err_vec;
   logic                 r_err_pulse;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state           <= S_IDLE;
         r_drain_cnt       <= 4'd0;
         r_data_err_count  <= '0;
         r_cfg_err_count   <= '0;
         r_compare_count   <= '0;
         r_first_err_index <= '0;
         r_first_err_vec   <= '0;
         r_err_pulse       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= w_drain_nxt;
         r_err_pulse <= w_data_err || w_cfg_err;
         if (w_cmp_act && (r_compare_count != CNT_MAX))
            r_compare_count <= r_compare_count + 1'b1;
         if (w_data_err) begin
            // A zero error count means this is the first failure; counts never wrap.
            if (r_data_err_count == '0) begin
               r_first_err_index <= r_compare_count;
               r_first_err_vec   <= w_diff;
            end
            if (r_data_err_count != CNT_MAX)
               r_data_err_count <= r_data_err_count + 1'b1;
         end
         if (w_cfg_err && (r_cfg_err_count != CNT_MAX))
            r_cfg_err_count <= r_cfg_err_count + 1'b1;
      end
   end

   assign o_data_err_count  = r_data_err_count;
   assign o_cfg_err_count   = r_cfg_err_count;
   assign o_compare_count   = r_compare_count;
   assign o_first_err_index = r_first_err_index;
   assign o_first_err_vec   = r_first_err_vec;
   assign o_err_pulse       = r_err_pulse;
   assign o_done            = (r_state == S_DONE);
   assign o_pass            = o_done && (r_data_err_count == '0) &&
                              (r_cfg_err_count == '0) && (r_compare_count != '0);
endmodule

// File: tb/tb_fabric_result_checker.sv
// Directed bench for fabric_result_checker: a transaction-level model checked every
// cycle against two instances (16-bit and 4-bit counters), plus literal end-of-test values.
module tb_fabric_result_checker;
   localparam int DOW = 36;
   localparam int LAT = 1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           check_en = 1'b0, cfg_valid = 1'b0, config_out = 1'b0;
   logic           exp_cfg = 1'b0, sim_done = 1'b0;
   logic [DOW-1:0] data_out = '0, exp_data = '0, mask = '0;

   logic [15:0]    u0_derr, u0_cerr, u0_cmp, u0_fidx;
   logic [3:0]     u1_derr, u1_cerr, u1_cmp, u1_fidx;
   logic [DOW-1:0] u0_fvec, u1_fvec;
   logic           u0_pulse, u0_done, u0_pass, u1_pulse, u1_done, u1_pass;

   always #5 clk = ~clk;

   fabric_result_checker #(.DATA_OUT_WIRE_WIDTH(DOW), .LATENCY(LAT), .CNT_WIDTH(16)) u0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_check_en(check_en), .i_data_out(data_out),
      .i_expected_dataout(exp_data), .i_dout_mask(mask), .i_cfg_valid(cfg_valid),
      .i_config_out(config_out), .i_expected_config_out(exp_cfg), .i_sim_done(sim_done),
      .o_data_err_count(u0_derr), .o_cfg_err_count(u0_cerr), .o_compare_count(u0_cmp),
      .o_first_err_index(u0_fidx), .o_first_err_vec(u0_fvec), .o_err_pulse(u0_pulse),
      .o_done(u0_done), .o_pass(u0_pass));

   fabric_result_checker #(.DATA_OUT_WIRE_WIDTH(DOW), .LATENCY(LAT), .CNT_WIDTH(4)) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_check_en(check_en), .i_data_out(data_out),
      .i_expected_dataout(exp_data), .i_dout_mask(mask), .i_cfg_valid(cfg_valid),
      .i_config_out(config_out), .i_expected_config_out(exp_cfg), .i_sim_done(sim_done),
      .o_data_err_count(u1_derr), .o_cfg_err_count(u1_cerr), .o_compare_count(u1_cmp),
      .o_first_err_index(u1_fidx), .o_first_err_vec(u1_fvec), .o_err_pulse(u1_pulse),
      .o_done(u1_done), .o_pass(u1_pass));

   int n_vec = 0;
   int n_miss = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: unbounded counts, golden data delayed by one cycle.
   typedef enum {P_IDLE, P_RUN, P_DRAIN, P_DONE} phase_t;
   phase_t         m_phase;
   int             m_left, m_cmp, m_derr, m_cerr, m_fidx;
   logic [DOW-1:0] m_fvec, m_pexp, m_pmask, m_diff;
   logic           m_pv, m_pulse;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = P_IDLE; m_left = 0; m_cmp = 0; m_derr = 0; m_cerr = 0; m_fidx = 0;
         m_fvec = '0; m_pexp = '0; m_pmask = '0; m_pv = 1'b0; m_pulse = 1'b0;
      end else begin
         m_pulse = 1'b0;
         if ((m_phase == P_RUN || m_phase == P_DRAIN) && m_pv) begin
            m_diff = (data_out ^ m_pexp) & m_pmask;
            if (m_diff != '0) begin
               if (m_derr == 0) begin m_fidx = m_cmp; m_fvec = m_diff; end
               m_derr++;
               m_pulse = 1'b1;
            end
            m_cmp++;
         end
         if (m_phase != P_DONE && cfg_valid && (config_out != exp_cfg)) begin
            m_cerr++;
            m_pulse = 1'b1;
         end
         case (m_phase)
            P_IDLE:  if (sim_done) begin m_phase = P_DRAIN; m_left = LAT + 1; end
                     else if (check_en || cfg_valid) m_phase = P_RUN;
            P_RUN:   if (sim_done) begin m_phase = P_DRAIN; m_left = LAT + 1; end
            P_DRAIN: begin m_left--; if (m_left == 0) m_phase = P_DONE; end
            default: ;
         endcase
         m_pv = check_en; m_pexp = exp_data; m_pmask = mask;
      end
   end

   function automatic int sat4(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   int pulses = 0;

   always @(negedge clk) begin
      logic m_done, m_pass;
      m_done = (m_phase == P_DONE);
      m_pass = m_done && m_derr == 0 && m_cerr == 0 && m_cmp != 0;
      if (u0_pulse) pulses++;
      chk("u0_cmp",   u0_cmp,   64'(m_cmp));
      chk("u0_derr",  u0_derr,  64'(m_derr));
      chk("u0_cerr",  u0_cerr,  64'(m_cerr));
      chk("u0_fidx",  u0_fidx,  64'(m_fidx));
      chk("u0_fvec",  u0_fvec,  64'(m_fvec));
      chk("u0_pulse", u0_pulse, 64'(m_pulse));
      chk("u0_done",  u0_done,  64'(m_done));
      chk("u0_pass",  u0_pass,  64'(m_pass));
      chk("u1_cmp",   u1_cmp,   64'(sat4(m_cmp)));
      chk("u1_derr",  u1_derr,  64'(sat4(m_derr)));
      chk("u1_cerr",  u1_cerr,  64'(sat4(m_cerr)));
      chk("u1_fidx",  u1_fidx,  64'(sat4(m_fidx)));
      chk("u1_pulse", u1_pulse, 64'(m_pulse));
      chk("u1_pass",  u1_pass,  64'(m_pass));
   end

   function automatic logic [DOW-1:0] pat(input int k);
      logic [31:0] h;
      h = 32'(k) * 32'h9E3779B9;
      return {4'(k), h};
   endfunction

   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0; check_en = 0; cfg_valid = 0; config_out = 0; exp_cfg = 0; sim_done = 0;
      data_out = '0; exp_data = '0; mask = '0;
      @(posedge clk); #2;
      rst_n = 1'b1;
   endtask

   // n compares; compares with index in [lo,hi] see data_out ^ flip.
   task automatic run_data(input int n, input int lo, input int hi,
                           input logic [DOW-1:0] flip, input logic [DOW-1:0] msk);
      logic [DOW-1:0] prev;
      prev = '0;
      for (int k = 0; k <= n; k++) begin
         @(posedge clk); #2;
         check_en = (k < n);
         exp_data = pat(k);
         mask     = msk;
         data_out = (k == 0) ? '0 : (prev ^ ((k - 1 >= lo && k - 1 <= hi) ? flip : '0));
         prev     = exp_data;
      end
   endtask

   task automatic finish_run();
      @(posedge clk); #2;
      check_en = 0; cfg_valid = 0; sim_done = 1;
      for (int i = 0; i < 20 && !u0_done; i++) @(negedge clk);
      chk("done_wait", u0_done, 1);
   endtask

   localparam logic [DOW-1:0] FULL = '1;

   initial begin
      #1; chk("rst_cmp", u0_cmp, 0);
      chk("rst_done", u0_done, 0);
      do_reset();

      run_data(100, -1, -1, '0, FULL);
      finish_run();
      chk("t1_cmp", u0_cmp, 100);
      chk("t1_pass", u0_pass, 1);
      chk("t1_derr", u0_derr, 0);
      do_reset();

      run_data(100, 37, 37, 36'h200, FULL);
      finish_run();
      chk("t2_derr", u0_derr, 1);
      chk("t2_fidx", u0_fidx, 37);
      chk("t2_fvec", u0_fvec, 36'h200);
      chk("t2_pass", u0_pass, 0);
      do_reset();

      run_data(30, 0, 1000, 36'h4, ~36'h4);
      finish_run();
      chk("t3_derr", u0_derr, 0);
      chk("t3_pass", u0_pass, 1);
      do_reset();

      pulses = 0;
      for (int s = 1; s <= 10; s++) begin
         @(posedge clk); #2;
         cfg_valid  = 1'b1;
         exp_cfg    = s[0];
         config_out = s[0] ^ ((s == 3) || (s == 7));
         @(posedge clk); #2;
         cfg_valid = 1'b0;
      end
      finish_run();
      chk("t4_cerr", u0_cerr, 2);
      chk("t4_pulses", 64'(pulses), 2);
      chk("t4_pass", u0_pass, 0);
      do_reset();

      run_data(25, 3, 22, FULL, FULL);
      finish_run();
      chk("t5_u1_derr", u1_derr, 15);
      chk("t5_u1_fidx", u1_fidx, 3);
      chk("t5_u0_derr", u0_derr, 20);
      chk("t5_u0_fidx", u0_fidx, 3);
      do_reset();

      run_data(10, 2, 2, 36'h1, FULL);
      run_data(0, -1, -1, '0, FULL);
      @(posedge clk); #2;
      sim_done = 1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("t6_derr_clr", u0_derr, 0);
      chk("t6_cmp_clr", u0_cmp, 0);
      chk("t6_done_clr", u0_done, 0);
      chk("t6_pulse_clr", u0_pulse, 0);
      @(posedge clk); #2;
      rst_n = 1'b1; check_en = 0; sim_done = 1;
      finish_run();
      chk("t6_pass", u0_pass, 0);
      chk("t6_cmp", u0_cmp, 0);

      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
